// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed seven-segment display scanner.
package display_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_e;

  localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

  localparam int unsigned DEF_NUM_DIGITS   = 3;
  localparam int unsigned DEF_SCAN_DIV     = 100000;
  localparam int unsigned DEF_BLANK_CYCLES = 1000;

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Display-image update handshake between an upstream producer and the scanner.
interface seven_seg_scanner_if #(
  parameter int unsigned NUM_DIGITS = 3
) ();

  logic                    upd_valid;
  logic                    upd_ready;
  logic [4*NUM_DIGITS-1:0] upd_value;
  logic [NUM_DIGITS-1:0]   upd_dp;
  logic [NUM_DIGITS-1:0]   upd_blank;

  modport master (output upd_valid, upd_value, upd_dp, upd_blank, input upd_ready);
  modport slave  (input upd_valid, upd_value, upd_dp, upd_blank, output upd_ready);

endinterface

// File: rtl/hexto7seg.sv
// Hex nibble to active-high seven-segment pattern, bit order gfedcba.
module hexto7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'h00;
    unique case (hex)
      4'h0: seg_c = 7'h3F;
      4'h1: seg_c = 7'h06;
      4'h2: seg_c = 7'h5B;
      4'h3: seg_c = 7'h4F;
      4'h4: seg_c = 7'h66;
      4'h5: seg_c = 7'h6D;
      4'h6: seg_c = 7'h7D;
      4'h7: seg_c = 7'h07;
      4'h8: seg_c = 7'h7F;
      4'h9: seg_c = 7'h6F;
      4'hA: seg_c = 7'h77;
      4'hB: seg_c = 7'h7C;
      4'hC: seg_c = 7'h39;
      4'hD: seg_c = 7'h5E;
      4'hE: seg_c = 7'h79;
      4'hF: seg_c = 7'h71;
      default: seg_c = 7'h00;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment driver with blanking between digits and a
// double-buffered display image that only swaps on frame boundaries.
module seven_seg_scanner
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int unsigned SCAN_DIV     = DEF_SCAN_DIV,
  parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [4*NUM_DIGITS-1:0] upd_value,
  input  logic [NUM_DIGITS-1:0]   upd_dp,
  input  logic [NUM_DIGITS-1:0]   upd_blank,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   digit_en_n
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;

  typedef struct packed {
    logic [VAL_W-1:0]      value;
    logic [NUM_DIGITS-1:0] dp;
    logic [NUM_DIGITS-1:0] blank;
  } image_t;

  localparam image_t IMAGE_RESET = '{value: '0, dp: '0, blank: '1};

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  image_t                pend_q, pend_d;
  image_t                shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic [7:0]            seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0] digit_en_n_q, digit_en_n_d;

  logic       slot_end, last_idx, frame_end, accept, copy;
  logic [3:0] nib_sel;
  logic       dp_sel, blank_sel;
  logic [6:0] dec_seg_c;

  assign slot_end  = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign last_idx  = (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign frame_end = (state_q == ON) && slot_end && last_idx;
  assign accept    = upd_valid && !pending_q;
  assign copy      = pending_q && (frame_end || (state_q == OFF));

  assign upd_ready  = !pending_q;
  assign seg_n      = seg_n_q;
  assign digit_en_n = digit_en_n_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= OFF;
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_q       <= IMAGE_RESET;
      shadow_q     <= IMAGE_RESET;
      pending_q    <= 1'b0;
      seg_n_q      <= SEG_ALL_OFF;
      digit_en_n_q <= '1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      seg_n_q      <= seg_n_d;
      digit_en_n_q <= digit_en_n_d;
    end
  end

  // Scan sequencing: one slot counter spans the blank and lit phases of a digit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      OFF: begin
        cnt_d = '0;
        idx_d = '0;
        if (enable) state_d = BLANK;
      end
      BLANK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) state_d = ON;
      end
      ON: begin
        if (slot_end) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = last_idx ? '0 : idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = OFF;
    endcase
    if (!enable) begin
      state_d = OFF;
      cnt_d   = '0;
      idx_d   = '0;
    end
  end

  // Pending/shadow double buffer; a copy always wins over a new acceptance
  always_comb begin
    pend_d    = pend_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (copy) begin
      shadow_d  = pend_q;
      pending_d = 1'b0;
    end else if (accept) begin
      pend_d    = '{value: upd_value, dp: upd_dp, blank: upd_blank};
      pending_d = 1'b1;
    end
  end

  always_comb begin
    nib_sel   = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib_sel   = shadow_d.value[4*i +: 4];
        dp_sel    = shadow_d.dp[i];
        blank_sel = shadow_d.blank[i];
      end
    end
  end

  hexto7seg u_hexto7seg (
    .hex   (nib_sel),
    .seg_c (dec_seg_c)
  );

  // Outputs are computed from next state so the registered pins line up with state_q
  always_comb begin
    seg_n_d      = SEG_ALL_OFF;
    digit_en_n_d = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      digit_en_n_d[i] = !((state_d == ON) && (idx_d == IDX_W'(i)));
    end
    if ((state_d == ON) && !blank_sel) seg_n_d = {~dp_sel, ~dec_seg_c};
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with a per-cycle output scoreboard.
module tb_seven_seg_scanner;

  localparam int unsigned ND = 3;
  localparam int unsigned SD = 8;
  localparam int unsigned BC = 2;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [7:0]    seg_n;
  logic [ND-1:0] digit_en_n;

  seven_seg_scanner_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .upd_valid  (bus.upd_valid),
    .upd_ready  (bus.upd_ready),
    .upd_value  (bus.upd_value),
    .upd_dp     (bus.upd_dp),
    .upd_blank  (bus.upd_blank),
    .seg_n      (seg_n),
    .digit_en_n (digit_en_n)
  );

  typedef struct {
    logic [7:0] seg;
    logic [2:0] en;
  } exp_t;

  typedef struct {
    logic [11:0] value;
    logic [2:0]  dp;
    logic [2:0]  blank;
    logic [7:0]  s0;
    logic [7:0]  s1;
    logic [7:0]  s2;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[5];
  int   n_chk;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_slot(input logic [7:0] seg, input int d);
    exp_t e;
    for (int k = 0; k < int'(BC); k++) begin
      e.seg = 8'hFF; e.en = 3'b111;
      sb_q.push_back(e);
    end
    for (int k = 0; k < int'(SD - BC); k++) begin
      e.seg = seg; e.en = 3'b111 ^ (3'b001 << d);
      sb_q.push_back(e);
    end
  endtask

  task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
    push_slot(s0, 0);
    push_slot(s1, 1);
    push_slot(s2, 2);
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_underflow: got no expectation queued at %0t", $time);
    end else begin
      e = sb_q.pop_front();
      chk("seg_n", 32'(seg_n), 32'(e.seg));
      chk("digit_en_n", 32'(digit_en_n), 32'(e.en));
    end
  endtask

  task automatic idle_tick();
    exp_t e;
    e.seg = 8'hFF; e.en = 3'b111;
    sb_q.push_back(e);
    tick();
  endtask

  // Loads an image while in OFF: accepted on one edge, shadowed on the next
  task automatic load_off(input logic [11:0] value, input logic [2:0] dp, input logic [2:0] blank);
    chk("ready_before_load", 32'(bus.upd_ready), 32'd1);
    bus.upd_value = value;
    bus.upd_dp    = dp;
    bus.upd_blank = blank;
    bus.upd_valid = 1'b1;
    idle_tick();
    bus.upd_valid = 1'b0;
    chk("ready_while_pending", 32'(bus.upd_ready), 32'd0);
    idle_tick();
    chk("ready_after_copy", 32'(bus.upd_ready), 32'd1);
  endtask

  function automatic logic seq_ready(input int t);
    return (t <= 11) || (t == 25) || (t >= 49);
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    enable = 1'b0;
    bus.upd_valid = 1'b0;
    bus.upd_value = '0;
    bus.upd_dp    = '0;
    bus.upd_blank = '0;

    vecs[0] = '{12'h5A3, 3'b000, 3'b000, 8'hB0, 8'h88, 8'h92};
    vecs[1] = '{12'h012, 3'b111, 3'b000, 8'h24, 8'h79, 8'h40};
    vecs[2] = '{12'h987, 3'b000, 3'b110, 8'hF8, 8'hFF, 8'hFF};
    vecs[3] = '{12'h5A3, 3'b010, 3'b100, 8'hB0, 8'h08, 8'hFF};
    vecs[4] = '{12'hFFF, 3'b000, 3'b000, 8'h8E, 8'h8E, 8'h8E};

    repeat (2) @(negedge clk);
    chk("reset_seg_n", 32'(seg_n), 32'hFF);
    chk("reset_digit_en_n", 32'(digit_en_n), 32'h7);
    chk("reset_ready", 32'(bus.upd_ready), 32'd1);
    rst_n = 1'b1;

    repeat (10) begin
      idle_tick();
      chk("ready_idle", 32'(bus.upd_ready), 32'd1);
    end

    // Table: load in OFF, scan two full frames, then disable
    foreach (vecs[v]) begin
      load_off(vecs[v].value, vecs[v].dp, vecs[v].blank);
      enable = 1'b1;
      repeat (2) push_frame(vecs[v].s0, vecs[v].s1, vecs[v].s2);
      repeat (48) tick();
      enable = 1'b0;
      idle_tick();
    end

    // Mid-frame update waits for the boundary; a held second request follows it
    load_off(12'h5A3, 3'b000, 3'b000);
    enable = 1'b1;
    push_frame(8'hB0, 8'h88, 8'h92);
    push_frame(8'h8E, 8'h8E, 8'h8E);
    push_frame(8'hA4, 8'hF9, 8'hC0);
    for (int t = 1; t <= 72; t++) begin
      tick();
      chk("ready_seq", 32'(bus.upd_ready), 32'(seq_ready(t)));
      if (t == 11) begin
        bus.upd_value = 12'hFFF;
        bus.upd_dp    = 3'b000;
        bus.upd_blank = 3'b000;
        bus.upd_valid = 1'b1;
      end else if (t == 12) begin
        bus.upd_value = 12'h012;
      end else if (t == 26) begin
        bus.upd_valid = 1'b0;
      end
    end

    // Disable mid-frame, re-enable restarts at digit 0
    push_frame(8'hA4, 8'hF9, 8'hC0);
    repeat (12) tick();
    sb_q.delete();
    enable = 1'b0;
    idle_tick();
    enable = 1'b1;
    push_frame(8'hA4, 8'hF9, 8'hC0);
    repeat (24) tick();
    enable = 1'b0;
    idle_tick();

    // Asynchronous reset mid-ON discards the pending image
    load_off(12'h5A3, 3'b000, 3'b000);
    enable = 1'b1;
    push_frame(8'hB0, 8'h88, 8'h92);
    repeat (5) tick();
    bus.upd_value = 12'hFFF;
    bus.upd_valid = 1'b1;
    tick();
    bus.upd_valid = 1'b0;
    chk("ready_pending_before_reset", 32'(bus.upd_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_seg_n", 32'(seg_n), 32'hFF);
    chk("async_reset_digit_en_n", 32'(digit_en_n), 32'h7);
    chk("async_reset_ready", 32'(bus.upd_ready), 32'd1);
    sb_q.delete();
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle_tick();
    enable = 1'b1;
    push_frame(8'hFF, 8'hFF, 8'hFF);
    repeat (24) tick();
    enable = 1'b0;
    idle_tick();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
